// File: rtl/axis_lane_accumulator.sv
// Multi-lane AXI-Stream packet accumulator.
// Sums signed lanes per packet and emits one result beat.
module axis_lane_accumulator #(
   parameter int LANES  = 1,
   parameter int LANE_W = 64,
   parameter int SAT_EN = 1
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic                      accu_en,
   output logic                      accu_finished,
   output logic [LANES-1:0]          sat_ovf,
   output logic                      len_ovf,
   output logic [15:0]               beat_cnt,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   input  logic [LANES*LANE_W-1:0]   s_axis_tdata,
   input  logic [LANES*LANE_W/8-1:0] s_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [LANES*LANE_W-1:0]   m_axis_tdata,
   output logic [LANES*LANE_W/8-1:0] m_axis_tkeep
);

   localparam int DATA_W = LANES * LANE_W;
   localparam int KEEP_W = DATA_W / 8;
   localparam int ACC_W  = LANE_W + 16;
   localparam int KB     = LANE_W / 8;

   localparam logic [LANE_W-1:0] L_MAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] L_MIN = {1'b1, {(LANE_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_OUTPUT,
      S_DONE
   } state_t;

   state_t              r_state;
   logic                r_s_tready;
   logic                r_m_tvalid;
   logic                r_m_tlast;
   logic [KEEP_W-1:0]   r_m_tkeep;
   logic [DATA_W-1:0]   r_m_tdata;
   logic                r_fin;
   logic [LANES-1:0]    r_sat_ovf;
   logic                r_len_ovf;
   logic [15:0]         r_beat;
   logic [ACC_W-1:0]    r_acc [LANES];

   logic [ACC_W-1:0]    w_acc_nxt [LANES];
   logic [DATA_W-1:0]   w_res;
   logic [LANES-1:0]    w_ovf;

   // Per-lane next sum, range check and result formatting.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [LANE_W-1:0]      w_smp;
      logic [ACC_W-1:0]       w_ext;
      logic                   w_keep;
      logic [ACC_W-LANE_W:0]  w_top;

      assign w_smp  = s_axis_tdata[g*LANE_W +: LANE_W];
      assign w_keep = &s_axis_tkeep[g*KB +: KB];
      assign w_ext  = {{16{w_smp[LANE_W-1]}}, w_smp};

      assign w_acc_nxt[g] = w_keep ? (r_acc[g] + w_ext) : r_acc[g];

      // Sum fits iff all bits above the lane sign bit match it.
      assign w_top    = w_acc_nxt[g][ACC_W-1:LANE_W-1];
      assign w_ovf[g] = ~((&w_top) | ~(|w_top));

      assign w_res[g*LANE_W +: LANE_W] =
         ((SAT_EN != 0) && w_ovf[g]) ?
            (w_top[ACC_W-LANE_W] ? L_MIN : L_MAX) :
            w_acc_nxt[g][LANE_W-1:0];
   end

   // Control FSM with registered stream, status and accumulator state.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= S_IDLE;
         r_s_tready <= 1'b0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tkeep  <= '0;
         r_m_tdata  <= '0;
         r_fin      <= 1'b0;
         r_sat_ovf  <= '0;
         r_len_ovf  <= 1'b0;
         r_beat     <= '0;
         for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (accu_en) begin
                  r_state    <= S_ACCUM;
                  r_s_tready <= 1'b1;
                  r_sat_ovf  <= '0;
                  r_len_ovf  <= 1'b0;
                  r_beat     <= '0;
                  for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
               end
            end
            S_ACCUM: begin
               if (!accu_en) begin
                  r_state    <= S_IDLE;
                  r_s_tready <= 1'b0;
               end else if (s_axis_tvalid) begin
                  for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_nxt[i];
                  if (r_beat == 16'hFFFF) r_len_ovf <= 1'b1;
                  else                    r_beat    <= r_beat + 16'd1;
                  if (s_axis_tlast) begin
                     r_state    <= S_OUTPUT;
                     r_s_tready <= 1'b0;
                     r_m_tvalid <= 1'b1;
                     r_m_tlast  <= 1'b1;
                     r_m_tkeep  <= '1;
                     r_m_tdata  <= w_res;
                     r_sat_ovf  <= w_ovf;
                  end
               end
            end
            S_OUTPUT: begin
               if (m_axis_tready) begin
                  r_state    <= S_DONE;
                  r_m_tvalid <= 1'b0;
                  r_m_tlast  <= 1'b0;
                  r_m_tkeep  <= '0;
                  r_fin      <= 1'b1;
               end
            end
            S_DONE: begin
               r_fin   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_axis_tready = r_s_tready;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tdata  = r_m_tdata;
   assign accu_finished = r_fin;
   assign sat_ovf       = r_sat_ovf;
   assign len_ovf       = r_len_ovf;
   assign beat_cnt      = r_beat;

endmodule

// File: tb/tb_axis_lane_accumulator.sv
// Directed bench for axis_lane_accumulator.
// Saturating and wrapping 4x16 instances plus a default 1x64 instance.
`timescale 1ns/1ps
module tb_axis_lane_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        s_tvalid;
   logic        s_tlast;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic [63:0] d64;
   logic [7:0]  k64;
   logic        m_tready;

   logic        fin, lovf, s_tready, m_tvalid, m_tlast;
   logic [3:0]  ovf;
   logic [15:0] bcnt;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;

   logic        w_fin, w_lovf, w_s_tready, w_m_tvalid, w_m_tlast;
   logic [3:0]  w_ovf;
   logic [15:0] w_bcnt;
   logic [63:0] w_m_tdata;
   logic [7:0]  w_m_tkeep;

   logic        x_fin, x_lovf, x_s_tready, x_m_tvalid, x_m_tlast;
   logic [0:0]  x_ovf;
   logic [15:0] x_bcnt;
   logic [63:0] x_m_tdata;
   logic [7:0]  x_m_tkeep;

   int nchk = 0;
   int nerr = 0;

   logic [63:0] pd  [16];
   logic [7:0]  pk  [16];
   logic [63:0] p64 [16];
   int          pn;
   logic [63:0] c_sat, c_wrap, c64;

   typedef struct {
      int              n;
      logic [2:0][63:0] d;
      logic [2:0][7:0]  k;
      logic [63:0]     es;
      logic [63:0]     ew;
      logic [3:0]      ov;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   axis_lane_accumulator #(.LANES(4), .LANE_W(16), .SAT_EN(1)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .accu_en(en),
      .accu_finished(fin), .sat_ovf(ovf), .len_ovf(lovf),
      .beat_cnt(bcnt),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep)
   );

   axis_lane_accumulator #(.LANES(4), .LANE_W(16), .SAT_EN(0)) dut_w (
      .sys_clk(clk), .sys_rst_n(rst_n), .accu_en(en),
      .accu_finished(w_fin), .sat_ovf(w_ovf), .len_ovf(w_lovf),
      .beat_cnt(w_bcnt),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(w_s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep),
      .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(w_m_tlast), .m_axis_tdata(w_m_tdata),
      .m_axis_tkeep(w_m_tkeep)
   );

   axis_lane_accumulator dut64 (
      .sys_clk(clk), .sys_rst_n(rst_n), .accu_en(en),
      .accu_finished(x_fin), .sat_ovf(x_ovf), .len_ovf(x_lovf),
      .beat_cnt(x_bcnt),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(x_s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tdata(d64),
      .s_axis_tkeep(k64),
      .m_axis_tvalid(x_m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(x_m_tlast), .m_axis_tdata(x_m_tdata),
      .m_axis_tkeep(x_m_tkeep)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // valid / finished / s_tready of all three instances at once
   task automatic chk_ctrl(input string nm, input logic v,
                           input logic f, input logic r);
      chk({nm, "_tvalid"}, 64'({m_tvalid, w_m_tvalid, x_m_tvalid}),
          64'({3{v}}));
      chk({nm, "_fin"}, 64'({fin, w_fin, x_fin}), 64'({3{f}}));
      chk({nm, "_sready"}, 64'({s_tready, w_s_tready, x_s_tready}),
          64'({3{r}}));
   endtask

   task automatic run_pkt(input int hold);
      int t;
      en = 1'b1;
      t = 0;
      while (!s_tready && t < 10) begin
         tick();
         t++;
      end
      chk("arm_ready", 64'(s_tready), 64'd1);
      for (int i = 0; i < pn; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = pd[i];
         s_tkeep  = pk[i];
         d64      = p64[i];
         s_tlast  = (i == pn - 1);
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      en       = 1'b0;
      chk_ctrl("result", 1'b1, 1'b0, 1'b0);
      chk("out_tlast", 64'({m_tlast, w_m_tlast, x_m_tlast}), 64'h7);
      chk("out_tkeep", 64'({m_tkeep, w_m_tkeep, x_m_tkeep}),
          64'hFF_FFFF);
      c_sat  = m_tdata;
      c_wrap = w_m_tdata;
      c64    = x_m_tdata;
      for (int h = 0; h < hold; h++) begin
         tick();
         chk_ctrl("hold", 1'b1, 1'b0, 1'b0);
         chk("hold_data", m_tdata, c_sat);
         chk("hold_tlast", 64'(m_tlast), 64'd1);
      end
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      chk_ctrl("done", 1'b0, 1'b1, 1'b0);
      tick();
      chk_ctrl("idle", 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      d64      = '0;
      k64      = 8'hFF;
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) p64[i] = '0;

      tbl[0].n = 2;
      tbl[0].d[0] = 64'h7FFF_7FFF_7FFF_7FFF; tbl[0].k[0] = 8'hFF;
      tbl[0].d[1] = 64'h7FFF_7FFF_7FFF_7FFF; tbl[0].k[1] = 8'hFF;
      tbl[0].d[2] = '0;                      tbl[0].k[2] = '0;
      tbl[0].es = 64'h7FFF_7FFF_7FFF_7FFF;
      tbl[0].ew = 64'hFFFE_FFFE_FFFE_FFFE;
      tbl[0].ov = 4'b1111;

      tbl[1].n = 2;
      tbl[1].d[0] = 64'h0005_0005_0005_0005; tbl[1].k[0] = 8'hFF;
      tbl[1].d[1] = 64'h0007_0007_0007_0007; tbl[1].k[1] = 8'h0F;
      tbl[1].d[2] = '0;                      tbl[1].k[2] = '0;
      tbl[1].es = 64'h0005_0005_000C_000C;
      tbl[1].ew = 64'h0005_0005_000C_000C;
      tbl[1].ov = 4'b0000;

      tbl[2].n = 2;
      tbl[2].d[0] = 64'h8000_8000_8000_8000; tbl[2].k[0] = 8'hFF;
      tbl[2].d[1] = 64'h8000_8000_8000_8000; tbl[2].k[1] = 8'hFF;
      tbl[2].d[2] = '0;                      tbl[2].k[2] = '0;
      tbl[2].es = 64'h8000_8000_8000_8000;
      tbl[2].ew = 64'h0000_0000_0000_0000;
      tbl[2].ov = 4'b1111;

      tbl[3].n = 3;
      tbl[3].d[0] = 64'h7FFF_4000_FFFF_0001; tbl[3].k[0] = 8'hFF;
      tbl[3].d[1] = 64'h0001_4000_FFFF_0002; tbl[3].k[1] = 8'hFF;
      tbl[3].d[2] = 64'h0000_FFFF_FFFF_0003; tbl[3].k[2] = 8'hFF;
      tbl[3].es = 64'h7FFF_7FFF_FFFD_0006;
      tbl[3].ew = 64'h8000_7FFF_FFFD_0006;
      tbl[3].ov = 4'b1000;

      tbl[4].n = 1;
      tbl[4].d[0] = 64'h1234_5678_9ABC_DEF0; tbl[4].k[0] = 8'h00;
      tbl[4].d[1] = '0;                      tbl[4].k[1] = '0;
      tbl[4].d[2] = '0;                      tbl[4].k[2] = '0;
      tbl[4].es = 64'h0;
      tbl[4].ew = 64'h0;
      tbl[4].ov = 4'b0000;

      tbl[5].n = 1;
      tbl[5].d[0] = 64'h0003_0002_0001_FFFC; tbl[5].k[0] = 8'h7F;
      tbl[5].d[1] = '0;                      tbl[5].k[1] = '0;
      tbl[5].d[2] = '0;                      tbl[5].k[2] = '0;
      tbl[5].es = 64'h0000_0002_0001_FFFC;
      tbl[5].ew = 64'h0000_0002_0001_FFFC;
      tbl[5].ov = 4'b0000;

      #2;
      chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_stat", 64'({ovf, lovf, bcnt, m_tkeep, m_tlast}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_ctrl("idle0", 1'b0, 1'b0, 1'b0);

      for (int v = 0; v < 6; v++) begin
         pn = tbl[v].n;
         for (int i = 0; i < 3; i++) begin
            pd[i] = tbl[v].d[i];
            pk[i] = tbl[v].k[i];
         end
         run_pkt((v == 3) ? 5 : 0);
         chk($sformatf("v%0d_sat", v), c_sat, tbl[v].es);
         chk($sformatf("v%0d_wrap", v), c_wrap, tbl[v].ew);
         chk($sformatf("v%0d_ovf", v), 64'({ovf, w_ovf}),
             64'({tbl[v].ov, tbl[v].ov}));
         chk($sformatf("v%0d_cnt", v), 64'({bcnt, w_bcnt}),
             64'({16'(tbl[v].n), 16'(tbl[v].n)}));
         chk($sformatf("v%0d_lovf", v), 64'({lovf, w_lovf}), 64'd0);
      end

      pn = 10;
      for (int i = 0; i < 10; i++) begin
         pd[i]  = '0;
         pk[i]  = 8'hFF;
         p64[i] = 64'(10 - 10 * i);
      end
      run_pkt(0);
      chk("w64_sum", c64, 64'hFFFF_FFFF_FFFF_FEA2);
      chk("w64_cnt", 64'(x_bcnt), 64'd10);
      chk("w64_ovf", 64'({x_ovf, x_lovf}), 64'd0);
      for (int i = 0; i < 10; i++) p64[i] = '0;

      en = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 64'h0064_0064_0064_0064;
         s_tkeep  = 8'hFF;
         tick();
      end
      s_tvalid = 1'b0;
      en = 1'b0;
      tick();
      chk_ctrl("abort", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_ctrl("abort_q", 1'b0, 1'b0, 1'b0);
      end
      pn = 2;
      pd[0] = 64'h0002_0002_0002_0002; pk[0] = 8'hFF;
      pd[1] = 64'h0003_0003_0003_0003; pk[1] = 8'hFF;
      run_pkt(0);
      chk("rearm_sum", c_sat, 64'h0005_0005_0005_0005);
      chk("rearm_cnt", 64'(bcnt), 64'd2);

      en = 1'b1;
      tick();
      s_tvalid = 1'b1;
      s_tlast  = 1'b1;
      s_tdata  = 64'h0009_0009_0009_0009;
      s_tkeep  = 8'hFF;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      en = 1'b0;
      chk_ctrl("pre_rst", 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_ctrl("mid_rst", 1'b0, 1'b0, 1'b0);
      chk("mid_rst_data", m_tdata, 64'd0);
      chk("mid_rst_stat", 64'({ovf, lovf, bcnt, m_tkeep, m_tlast}), 64'd0);
      tick();
      rst_n = 1'b1;
      pn = 1;
      pd[0] = 64'hFFFC_FFFC_FFFC_FFFC; pk[0] = 8'hFF;
      run_pkt(0);
      chk("post_rst_sum", c_sat, 64'hFFFC_FFFC_FFFC_FFFC);
      chk("post_rst_cnt", 64'(bcnt), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/axis_lane_accumulator.md
# axis_lane_accumulator

Parametrised multi-lane successor to the single-channel stream accumulator. It sums signed AXI-Stream samples per lane over one packet, delimited by `tlast`, and emits one result beat per packet. Each lane can saturate or wrap, and each lane reports its own overflow flag. It sits between the DMA MM2S stream and the DMA S2MM stream, under the same `accu_en` / `accu_finished` software control handshake.

## Interface
- `LANES`, default 1: number of independent signed lanes packed in `tdata`, lane 0 in the LSBs.
- `LANE_W`, default 64: lane width in bits; must be a multiple of 8.
- `SAT_EN`, default 1: 1 = saturate results to `LANE_W`; 0 = truncate (wrap).
- Derived: `DATA_W = LANES*LANE_W`, `KEEP_W = DATA_W/8`, `ACC_W = LANE_W+16` (internal accumulator width).

Ports:
- `sys_clk`  in  1  clock; all logic in this single domain.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `accu_en`  in  1  level enable; arms the block and holds it in a packet.
- `accu_finished`  out  1  one-cycle pulse after the result beat is accepted.
- `sat_ovf`  out  `LANES`  per-lane overflow flags for the last packet.
- `len_ovf`  out  1  last packet exceeded 65535 beats.
- `beat_cnt`  out  16  beats accepted in the current or last packet; saturating.
- `s_axis_tvalid` / `s_axis_tready` / `s_axis_tlast`  in/out/in  1 each.
- `s_axis_tdata`  in  `DATA_W`  signed lane samples.
- `s_axis_tkeep`  in  `KEEP_W`  byte enables.
- `m_axis_tvalid` / `m_axis_tready` / `m_axis_tlast`  out/in/out  1 each.
- `m_axis_tdata`  out  `DATA_W`  per-lane results.
- `m_axis_tkeep`  out  `KEEP_W`  all ones whenever `m_axis_tvalid=1`.

## Operation
- FSM states: IDLE, ACCUM, OUTPUT, DONE.
- IDLE → ACCUM when `accu_en=1` is sampled. On this transition the block clears all accumulators, `beat_cnt`, `sat_ovf` and `len_ovf`.
- ACCUM: `s_axis_tready=1`. On each handshake:
  - lane i adds its sign-extended sample to `acc[i]` only if all `LANE_W/8` of its `tkeep` bits are 1; otherwise the lane is untouched;
  - `beat_cnt` increments, saturating at 65535;
  - `len_ovf` is set on an accepted beat while `beat_cnt` is already 65535.
- ACCUM with `accu_en=0` → IDLE (abort). Partial sums are discarded; there is no output and no `accu_finished`.
- ACCUM handshake with `tlast=1` → OUTPUT. The `tlast` beat is included in the sum.
- Result for lane i:
  - `SAT_EN=1`: clamp `acc[i]` to [−2^(LANE_W−1), 2^(LANE_W−1)−1];
  - `SAT_EN=0`: take the low `LANE_W` bits;
  - in both modes `sat_ovf[i]=1` iff `acc[i]` lies outside the signed `LANE_W` range.
- `acc` wraps in `ACC_W`; the sum is exact up to 65536 beats.
- OUTPUT: `m_axis_tvalid=1`, `tlast=1`, `tkeep` all ones. This state ignores `accu_en`; once a result is pending it is always delivered.
- OUTPUT → DONE on `m_axis_tvalid & m_axis_tready`.
- DONE: `accu_finished=1` for exactly one cycle, then → IDLE.
- `sat_ovf`, `len_ovf` and `beat_cnt` hold their values until the next IDLE → ACCUM transition.

## Timing
- Reset value of every output is 0, applied asynchronously.
  - This includes reset asserted mid-ACCUM or mid-OUTPUT: `m_axis_tvalid` drops immediately and the pending result is lost.
- `s_axis_tready` rises in the cycle after `accu_en=1` is sampled in IDLE.
- `s_axis_tready` drops in the cycle after the `tlast` handshake; no beat after `tlast` is accepted.
- Result latency: `m_axis_tvalid` asserts the cycle after the `tlast` handshake, with the final sum registered.
- Backpressure: while `m_axis_tvalid & !m_axis_tready`, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tkeep` are held stable.
- If output handshake is at cycle N: `accu_finished=1` at N+1; IDLE at N+2; earliest `s_axis_tready` is N+3.
- A single-beat packet (`tlast` on the first beat) is legal, giving `beat_cnt=1`.
- `s_axis_tvalid=0` cycles inside a packet are legal and change nothing.

## Test plan
- LANES=1, LANE_W=64: 10 beats of 10, 0, −10, …, −80, `tlast` on beat 10 → one output beat with `tdata=−350`, `tlast=1`, `beat_cnt=10`, `sat_ovf=0`, `accu_finished` pulse one cycle after the handshake.
- LANES=4, LANE_W=16, SAT_EN=1: 2 beats, all lanes 0x7FFF → every lane 0x7FFF, `sat_ovf=4'b1111`. Same stimulus with SAT_EN=0 → every lane 0xFFFE, `sat_ovf=4'b1111`.
- LANES=4, LANE_W=16: beat 1 all lanes 5 with `tkeep=0xFF`; beat 2 all lanes 7 with `tkeep=0x0F`, `tlast` → lanes 0,1 = 12; lanes 2,3 = 5.
- Hold `m_axis_tready=0` for 5 cycles after the result appears → `tvalid` and `tdata` stable; `s_axis_tready=0`; `accu_finished` asserts only after `tready` goes high.
- Drop `accu_en` after 3 beats of 100 → no output beat and no `accu_finished`. Re-raise `accu_en`, send 2 then 3 with `tlast` → result 5, `beat_cnt=2`.
- Assert `sys_rst_n=0` while `m_axis_tvalid=1` → all outputs are 0 at once. After release with `accu_en=1`, a one-beat packet of −4 → result −4.
